// File: rtl/stereo_sample_scheduler.sv
// stereo_sample_scheduler
//   Shares one sample generator between the left and right codec channels.
//   On each generate_next pulse, aural_state picks the mode. The block issues
//   one request (mono, left-only, right-only) or two requests (stereo) and
//   collects the returned samples. It then presents a registered L/R pair
//   together with a one-cycle samples_ready.
//
//   Ports
//     clk, rst       clock, asynchronous active-high reset
//     aural_state    mode: 00 mono, 01 stereo, 10 left-only, 11 right-only
//     generate_next  codec pulse requesting the next pair
//     gen_valid      generator sample valid
//     gen_sample     generator sample, passed through unmodified
//     gen_req        one-cycle request to the generator
//     gen_chan       channel of the outstanding request (0 left, 1 right)
//     left_sample    registered left output
//     right_sample   registered right output
//     samples_ready  one-cycle strobe while the new pair is presented
//     timeout        one-cycle pulse after a request expired without data
//     overrun        generate_next arrived while a frame was in progress
module stereo_sample_scheduler #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       aural_state,
  input  logic             generate_next,
  input  logic             gen_valid,
  input  logic [WIDTH-1:0] gen_sample,
  output logic             gen_req,
  output logic             gen_chan,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic             samples_ready,
  output logic             timeout,
  output logic             overrun
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic             chan_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shadow0, shadow1;

  logic             expired, capture, more;
  logic [WIDTH-1:0] cap_val, sh0_n, sh1_n;

  // A request ends on data or on expiry. When both occur in the same cycle,
  // the data wins.
  assign expired = (cnt == CW'(TIMEOUT - 1));
  assign capture = (state == WAIT) && (gen_valid || expired);
  assign cap_val = gen_valid ? gen_sample : '0;
  // Shadow values including this cycle's capture. Outputs load from these
  // values, so the sample that closes the frame is visible immediately.
  assign sh0_n   = (capture && !chan_q) ? cap_val : shadow0;
  assign sh1_n   = (capture &&  chan_q) ? cap_val : shadow1;
  // Stereo needs a second (right) request after the left capture.
  assign more    = (mode_q == 2'b01) && !chan_q;

  assign gen_req       = (state == REQ);
  assign samples_ready = (state == DONE);
  assign gen_chan      = chan_q;
  assign overrun       = generate_next && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= 2'b00;
      chan_q       <= 1'b0;
      cnt          <= '0;
      shadow0      <= '0;
      shadow1      <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (generate_next) begin
          mode_q <= aural_state;
          chan_q <= (aural_state == 2'b11);
          state  <= REQ;
        end
        REQ: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (capture) begin
            shadow0 <= sh0_n;
            shadow1 <= sh1_n;
            timeout <= !gen_valid;
            if (more) begin
              chan_q <= 1'b1;
              state  <= REQ;
            end else begin
              state <= DONE;
              case (mode_q)
                2'b00: begin left_sample <= cap_val; right_sample <= cap_val; end
                2'b01: begin left_sample <= sh0_n;   right_sample <= sh1_n;   end
                2'b10: begin left_sample <= sh0_n;   right_sample <= '0;      end
                default: begin left_sample <= '0;    right_sample <= sh1_n;   end
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stereo_sample_scheduler.md
Name: stereo_sample_scheduler

Overview:
Per-frame scheduler that shares the single sample generator between the left and right codec channels. The sharing pattern is set by the 2-bit aural_state from stereo_mcu. On each codec generate_next pulse, the block issues one or two generator requests, collects the returned samples, and presents a registered left/right pair to the codec. A per-request timeout keeps the block from hanging if the generator stalls.

Parameters:
WIDTH, 16, sample width in bits
TIMEOUT, 64, maximum cycles spent waiting for gen_valid per request (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
aural_state  input  2  mode from stereo_mcu: 00 mono, 01 stereo, 10 left-only, 11 right-only
generate_next  input  1  one-cycle pulse from codec requesting the next sample pair
gen_valid  input  1  generator sample valid
gen_sample  input  WIDTH  generator sample, two's complement
gen_req  output  1  one-cycle request to generator
gen_chan  output  1  channel being requested (0 left, 1 right)
left_sample  output  WIDTH  registered left output
right_sample  output  WIDTH  registered right output
samples_ready  output  1  high for one cycle when the new pair is valid
timeout  output  1  one-cycle pulse when a request expires
overrun  output  1  one-cycle pulse when generate_next arrives while busy

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0; mode_q 00; shadow regs 0; timeout counter 0.
- States: IDLE, REQ, WAIT, DONE. The current channel is held in register chan_q, which drives gen_chan.
- IDLE:
  - On generate_next: latch aural_state into mode_q.
  - Set chan_q = 1 if aural_state==11, else 0.
  - Go to REQ.
- REQ: gen_req=1 for exactly this cycle. Go to WAIT. Clear the timeout counter.
- WAIT:
  - gen_chan is held. The counter increments each cycle.
  - On gen_valid: capture gen_sample into shadow[chan_q].
  - If timeout is reached (counter==TIMEOUT-1) with no gen_valid: capture 0 into shadow[chan_q] and pulse timeout.
  - gen_valid in the same cycle as expiry: valid wins, and timeout stays 0.
  - After a capture: if mode_q==01 and chan_q==0, set chan_q=1 and go to REQ. Otherwise go to DONE.
- Output update: left_sample and right_sample are written only on the edge entering DONE, both at once:
  - 00: L=R=captured sample
  - 01: L=shadow0, R=shadow1
  - 10: L=shadow0, R=0
  - 11: L=0, R=shadow1
- DONE: samples_ready=1 (state-decoded). Return to IDLE next cycle. Outputs hold until the next DONE.
- Latency, with generate_next sampled at cycle N and zero-wait generator (gen_valid in the first WAIT cycle):
  - Single request: gen_req at N+1, DONE at N+3.
  - Stereo: gen_req at N+1 and N+3, DONE at N+5.
- Mode changes: aural_state changes outside IDLE have no effect until the next frame.
- Busy frames: generate_next in REQ, WAIT or DONE is dropped and pulses overrun that cycle. The frame in progress is unaffected.
- Ignored input: gen_valid outside WAIT is ignored.
- Reset mid-frame: immediately returns to IDLE with all outputs cleared. No gen_req is emitted after reset deasserts until a new generate_next.
- No arithmetic is performed. Samples pass through unmodified. Mute is exact zero.

Test Plan:
- Mono: rst, aural_state=00, generate_next at N, gen_valid with 16'h1234 one cycle after gen_req -> single gen_req (gen_chan=0), samples_ready at N+3, L=R=16'h1234.
- Stereo: aural_state=01, generator returns 16'h0AAA then 16'hF555 -> gen_req at N+1 (chan 0) and N+3 (chan 1), samples_ready at N+5, L=16'h0AAA, R=16'hF555.
- Left-only and right-only: mode 10 with sample 16'h0042 -> L=16'h0042, R=0. Mode 11 -> one gen_req with gen_chan=1, L=0, R=16'h0042.
- Timeout: TIMEOUT=8, stereo, no gen_valid on the left request -> timeout pulse 8 cycles after entering WAIT, right request still issued, L=0, R=returned value. Also gen_valid on the expiry cycle -> no timeout pulse and the sample is captured.
- Overrun and mode change: second generate_next during WAIT, plus aural_state switched 01->00 mid-frame -> overrun pulse for one cycle, frame completes as stereo, next frame runs mono.
- Async reset mid-WAIT: rst pulsed between clock edges -> outputs 0 immediately, state IDLE, no gen_req until the next generate_next.
